opb_addr_decoder_n: RTL and testbench

- Parametrised OPB slave-select decoder with a registered read-return mux. Sits between the OPB bridge and the peripheral register blocks (counter, clock, DAC, ADC, motor, GPIO, EEPROM).
- Replaces per-peripheral hand-coded decodes and tristate DEC_DO drivers with NUM_SLV generic regions.
- Adds a ready/ack handshake, a per-read timeout, and error responses for unmapped or timed-out accesses.

---
 rtl/opb_dec_pkg.sv | 26 ++
 rtl/opb_addr_decoder_n_if.sv | 31 +++
 rtl/opb_dec_region_match.sv | 19 +
 rtl/opb_addr_decoder_n.sv | 167 ++++++++++++++++
 tb/tb_opb_addr_decoder_n.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/opb_dec_pkg.sv
// Shared types and defaults for the OPB slave-select decoder (opb_addr_decoder_n).
// Default region map: NUM_SLV windows of 0x40 bytes at 64 KiB strides.
package opb_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dec_state_t;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;
    localparam int          TO_CNT_W     = 8;
    localparam int          DEF_NUM_SLV  = 8;
    localparam int          DEF_ADDR_W   = 20;

    // sizes=0 builds the packed base vector, sizes=1 the packed size vector
    function automatic logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] def_region_vec(input bit sizes);
        logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEF_NUM_SLV; i++) begin
            v[i*DEF_ADDR_W +: DEF_ADDR_W] = sizes ? DEF_ADDR_W'(32'h40)
                                                  : DEF_ADDR_W'(32'h10000 * i);
        end
        return v;
    endfunction

endpackage

// File: rtl/opb_addr_decoder_n_if.sv
// Bridge-to-decoder-to-peripheral bundle; slave modport is the decoder's view,
// master modport is the bridge/peripheral side that drives requests and read data.
interface opb_addr_decoder_n_if #(
    parameter int NUM_SLV = 8,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32
);
    logic                      DEC_RE;
    logic                      DEC_WE;
    logic [31:0]               DEC_ADDR;
    logic [NUM_SLV*DATA_W-1:0] SLV_DI;
    logic [NUM_SLV-1:0]        SLV_RDY;
    logic [NUM_SLV-1:0]        SLV_RE;
    logic [NUM_SLV-1:0]        SLV_WE;
    logic [DATA_W-1:0]         DEC_DO;
    logic                      DEC_ACK;
    logic                      DEC_ERR;
    logic                      BUSY;
    logic [ADDR_W-1:0]         ERR_ADDR;
    logic [15:0]               ERR_CNT;

    modport slave (
        input  DEC_RE, DEC_WE, DEC_ADDR, SLV_DI, SLV_RDY,
        output SLV_RE, SLV_WE, DEC_DO, DEC_ACK, DEC_ERR, BUSY, ERR_ADDR, ERR_CNT
    );

    modport master (
        output DEC_RE, DEC_WE, DEC_ADDR, SLV_DI, SLV_RDY,
        input  SLV_RE, SLV_WE, DEC_DO, DEC_ACK, DEC_ERR, BUSY, ERR_ADDR, ERR_CNT
    );
endinterface

// File: rtl/opb_dec_region_match.sv
// One base/size window comparator, purely combinational (zero latency, no backpressure).
// Compared one bit wider than the address so BASE+SIZE cannot wrap.
module opb_dec_region_match #(
    parameter int                ADDR_W = 20,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] SIZE   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    logic [ADDR_W:0] a_x;
    logic [ADDR_W:0] lo_x;
    logic [ADDR_W:0] hi_x;

    assign a_x  = {1'b0, addr};
    assign lo_x = {1'b0, BASE};
    assign hi_x = {1'b0, BASE} + {1'b0, SIZE};
    assign hit  = (SIZE != '0) && (a_x >= lo_x) && (a_x < hi_x);
endmodule

// File: rtl/opb_addr_decoder_n.sv
// OPB slave-select decoder with registered read-return mux; writes/errors ack next cycle,
// reads ack the cycle after the selected RDY (or after TIMEOUT_CYC WAIT cycles); requests while BUSY are dropped. Optional ERR_CNT: OPB_DEC_ERRCNT_EN.
module opb_addr_decoder_n
    import opb_dec_pkg::*;
#(
    parameter int                        NUM_SLV     = DEF_NUM_SLV,
    parameter int                        ADDR_W      = DEF_ADDR_W,
    parameter int                        DATA_W      = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] BASE        = def_region_vec(1'b0),
    parameter logic [NUM_SLV*ADDR_W-1:0] SIZE        = def_region_vec(1'b1),
    parameter int                        TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0]         ERR_DATA    = DATA_W'(DEF_ERR_DATA)
) (
    input logic                 OPB_CLK,
    input logic                 OPB_RST,
    opb_addr_decoder_n_if.slave bus
);
    localparam int                IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    dec_state_t          state;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [DATA_W-1:0]   do_q;
    logic                ack_q;
    logic                err_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic [ADDR_W-1:0]   a;
    logic [NUM_SLV-1:0]  hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                any_hit;
    logic [NUM_SLV-1:0]  sel_oh;
    logic                idle;
    logic                rd_only;
    logic                wr_only;
    logic                rdy_sel;
    logic [DATA_W-1:0]   di_sel;

    assign a = bus.DEC_ADDR[ADDR_W-1:0];

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.DEC_ADDR[31:ADDR_W];
        end
        for (genvar g = 0; g < NUM_SLV; g++) begin : g_match
            opb_dec_region_match #(
                .ADDR_W (ADDR_W),
                .BASE   (BASE[g*ADDR_W +: ADDR_W]),
                .SIZE   (SIZE[g*ADDR_W +: ADDR_W])
            ) u_match (
                .addr (a),
                .hit  (hit[g])
            );
        end
    endgenerate

    // Lowest index wins on overlapping windows
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    assign sel_oh  = any_hit ? (NUM_SLV'(1) << hit_idx) : '0;
    assign idle    = (state == IDLE);
    assign rd_only = bus.DEC_RE & ~bus.DEC_WE;
    assign wr_only = bus.DEC_WE & ~bus.DEC_RE;
    assign rdy_sel = bus.SLV_RDY[idx_q];
    assign di_sel  = bus.SLV_DI[idx_q*DATA_W +: DATA_W];

    assign bus.SLV_RE = (rd_only && idle) ? sel_oh : '0;
    assign bus.SLV_WE = (wr_only && idle) ? sel_oh : '0;

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state      <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            to_cnt     <= '0;
            do_q       <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.DEC_RE || bus.DEC_WE) begin
                        if (rd_only && any_hit) begin
                            state  <= WAIT;
                            idx_q  <= hit_idx;
                            addr_q <= a;
                            to_cnt <= '0;
                        end else if (wr_only && any_hit) begin
                            ack_q <= 1'b1;
                        end else begin
                            // Unmapped, or RE and WE together: only a pure read returns ERR_DATA
                            ack_q      <= 1'b1;
                            err_q      <= 1'b1;
                            err_addr_q <= a;
                            if (rd_only) do_q <= ERR_DATA;
                        end
                    end
                end
                WAIT: begin
                    if (rdy_sel) begin
                        do_q   <= di_sel;
                        ack_q  <= 1'b1;
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        do_q       <= ERR_DATA;
                        ack_q      <= 1'b1;
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        state      <= IDLE;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.DEC_DO   = do_q;
    assign bus.DEC_ACK  = ack_q;
    assign bus.DEC_ERR  = err_q;
    assign bus.BUSY     = (state == WAIT);
    assign bus.ERR_ADDR = err_addr_q;

`ifdef OPB_DEC_ERRCNT_EN
    logic        err_evt;
    logic        drop_evt;
    logic [16:0] cnt_sum;
    logic [15:0] err_cnt_q;

    // Events counted on the edge that raises DEC_ERR, so ERR_CNT moves with it
    always_comb begin
        err_evt = 1'b0;
        if (idle) err_evt = (bus.DEC_RE | bus.DEC_WE) & ~((rd_only | wr_only) & any_hit);
        else      err_evt = ~rdy_sel & (to_cnt == TO_LAST);
    end

    assign drop_evt = ~idle & (bus.DEC_RE | bus.DEC_WE);
    assign cnt_sum  = {1'b0, err_cnt_q} + 17'(err_evt) + 17'(drop_evt);

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) err_cnt_q <= '0;
        else         err_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    assign bus.ERR_CNT = err_cnt_q;
`else
    assign bus.ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_opb_addr_decoder_n.sv
// Directed + randomized bench for opb_addr_decoder_n against a region-table transaction model.
module tb_opb_addr_decoder_n;
    localparam int          NS   = 8;
    localparam int          TMO  = 16;
    localparam logic [31:0] EDAT = 32'hDEADBEEF;

    logic OPB_CLK = 1'b0;
    logic OPB_RST = 1'b1;

    opb_addr_decoder_n_if #(.NUM_SLV(NS), .ADDR_W(20), .DATA_W(32)) bus ();

    opb_addr_decoder_n u_dut (
        .OPB_CLK (OPB_CLK),
        .OPB_RST (OPB_RST),
        .bus     (bus)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int          checks = 0;
    int          errors = 0;
    int unsigned m_base [NS];
    int unsigned m_size [NS];
    logic [31:0] m_do;
    logic [19:0] m_err_addr;
    int          m_errcnt;

    function automatic int region_of(input logic [31:0] addr);
        int unsigned a;
        a = {12'd0, addr[19:0]};
        for (int i = 0; i < NS; i++)
            if (m_size[i] != 0 && a >= m_base[i] && a < m_base[i] + m_size[i]) return i;
        return -1;
    endfunction

    task automatic bump();
`ifdef OPB_DEC_ERRCNT_EN
        if (m_errcnt < 65535) m_errcnt++;
`endif
    endtask

    task automatic model_reset();
        m_do       = '0;
        m_err_addr = '0;
        m_errcnt   = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ack, input logic err, input logic busy);
        chk({tag, ".ack"},  64'(bus.DEC_ACK),  64'(ack));
        chk({tag, ".err"},  64'(bus.DEC_ERR),  64'(err));
        chk({tag, ".busy"}, 64'(bus.BUSY),     64'(busy));
        chk({tag, ".do"},   64'(bus.DEC_DO),   64'(m_do));
        chk({tag, ".eadr"}, 64'(bus.ERR_ADDR), 64'(m_err_addr));
        chk({tag, ".ecnt"}, 64'(bus.ERR_CNT),  64'(m_errcnt));
    endtask

    task automatic rand_di();
        for (int s = 0; s < NS; s++) bus.SLV_DI[s*32 +: 32] = $urandom;
    endtask

    // op: 0 read, 1 write, 2 RE+WE together. lat: WAIT cycle with RDY (>TMO = never).
    // drop_at: WAIT cycle in which a second request is issued (0 = none).
    task automatic txn(input int op, input logic [31:0] addr, input int lat,
                       input logic [31:0] rdat, input int drop_at);
        int       idx;
        logic [7:0] oh;
        idx = region_of(addr);
        oh  = (idx >= 0) ? 8'(1 << idx) : 8'h00;
        bus.DEC_ADDR = addr;
        bus.DEC_RE   = (op != 1);
        bus.DEC_WE   = (op != 0);
        bus.SLV_RDY  = 8'($urandom);
        rand_di();
        #1;
        chk("slv_re", 64'(bus.SLV_RE), 64'((op == 0) ? oh : 8'h00));
        chk("slv_we", 64'(bus.SLV_WE), 64'((op == 1) ? oh : 8'h00));
        @(negedge OPB_CLK);
        bus.DEC_RE  = 1'b0;
        bus.DEC_WE  = 1'b0;
        bus.SLV_RDY = '0;
        if (idx < 0 || op == 2) begin
            m_err_addr = addr[19:0];
            if (op == 0) m_do = EDAT;
            bump();
            chk_outs("unmapped", 1'b1, 1'b1, 1'b0);
        end else if (op == 1) begin
            chk_outs("write", 1'b1, 1'b0, 1'b0);
        end else begin
            chk_outs("rd_wait0", 1'b0, 1'b0, 1'b1);
            for (int w = 1; w <= TMO; w++) begin
                rand_di();
                bus.SLV_RDY = 8'($urandom) & ~oh;
                if (w == lat) begin
                    bus.SLV_RDY[idx]         = 1'b1;
                    bus.SLV_DI[idx*32 +: 32] = rdat;
                end
                if (w == drop_at) begin
                    bus.DEC_ADDR = $urandom;
                    bus.DEC_RE   = $urandom_range(0, 1) == 1;
                    bus.DEC_WE   = ~bus.DEC_RE;
                    #1;
                    chk("drop_re", 64'(bus.SLV_RE), 64'(0));
                    chk("drop_we", 64'(bus.SLV_WE), 64'(0));
                    bump();
                end
                @(negedge OPB_CLK);
                bus.DEC_RE  = 1'b0;
                bus.DEC_WE  = 1'b0;
                bus.SLV_RDY = '0;
                if (w == lat) begin
                    m_do = rdat;
                    chk_outs("rd_done", 1'b1, 1'b0, 1'b0);
                    break;
                end else if (w == TMO) begin
                    m_do       = EDAT;
                    m_err_addr = addr[19:0];
                    bump();
                    chk_outs("rd_tmo", 1'b1, 1'b1, 1'b0);
                end else begin
                    chk_outs("rd_wait", 1'b0, 1'b0, 1'b1);
                end
            end
        end
    endtask

    initial begin
        int          op;
        int          sidx;
        logic [31:0] addr;
        for (int i = 0; i < NS; i++) begin
            m_base[i] = i * 32'h10000;
            m_size[i] = 32'h40;
        end
        model_reset();
        bus.DEC_RE   = 1'b0;
        bus.DEC_WE   = 1'b0;
        bus.DEC_ADDR = '0;
        bus.SLV_RDY  = '0;
        bus.SLV_DI   = '0;

        repeat (2) @(negedge OPB_CLK);
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.slv_re", 64'(bus.SLV_RE), 64'(0));
        OPB_RST = 1'b0;
        @(negedge OPB_CLK);

        txn(1, 32'h0001_0004, 0, 32'h0, 0);
        txn(0, 32'h0002_0000, 1, 32'h1234_5678, 0);

        // Reset during WAIT, then a late RDY from the abandoned slave
        bus.DEC_ADDR = 32'h0005_0000;
        bus.DEC_RE   = 1'b1;
        #1 chk("rst.slv_re", 64'(bus.SLV_RE), 64'(8'h20));
        @(negedge OPB_CLK);
        bus.DEC_RE = 1'b0;
        chk_outs("rst.wait", 1'b0, 1'b0, 1'b1);
        @(negedge OPB_CLK);
        OPB_RST = 1'b1;
        #1;
        model_reset();
        chk_outs("rst.mid", 1'b0, 1'b0, 1'b0);
        @(negedge OPB_CLK);
        OPB_RST     = 1'b0;
        bus.SLV_RDY = 8'h20;
        rand_di();
        @(negedge OPB_CLK);
        bus.SLV_RDY = '0;
        chk_outs("rst.late_rdy", 1'b0, 1'b0, 1'b0);
        txn(0, 32'h0005_0010, 2, 32'hCAFE_0005, 0);

        // Second request while BUSY is dropped
        txn(0, 32'h0004_0008, 5, 32'hA5A5_0004, 2);

        txn(0, 32'h0003_0000, TMO + 5, 32'h0, 0);
        txn(0, 32'h0000_0040, 0, 32'h0, 0);
        txn(1, 32'h0000_0040, 0, 32'h0, 0);
        txn(2, 32'h0006_0000, 0, 32'h0, 0);
        txn(0, 32'h0007_003C, TMO, 32'h7777_0007, 0);

        for (int n = 0; n < 80; n++) begin
            op   = $urandom_range(0, 9);
            op   = (op < 5) ? 0 : (op < 9) ? 1 : 2;
            sidx = $urandom_range(0, NS - 1);
            addr = {12'($urandom), 20'(sidx * 32'h10000 + $urandom_range(0, 32'h47))};
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            txn(op, addr, $urandom_range(1, TMO + 2), $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge OPB_CLK);
                chk_outs("gap", 1'b0, 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
